// File: rtl/tx_fifo_gearbox.sv
// tx_fifo_gearbox
//   First-word-fall-through FIFO that accepts wide words and emits them one
//   narrow lane at a time. Each wide word carries its own lane count, so a
//   partial final word emits only its first lanes in the selected lane order.
//
// Ports
//   clk          : single clock
//   rst          : asynchronous active-low reset
//   flush        : synchronous clear of all contents (beats wr_en / rd_en)
//   wr_en        : write request, accepted on wr_en & wr_vld
//   wr_data      : wide write word, RATIO lanes of RD_DATA_WIDTH bits
//   wr_lanes     : valid lanes in wr_data, 1..RATIO (0 means RATIO)
//   wr_vld       : space available for one more wide word
//   almost_full  : stored wide entries >= AFULL_THRESH (registered)
//   rd_en        : pop request, acts on rd_en & rd_vld
//   rd_vld       : rd_data holds a valid lane
//   rd_data      : current lane
//   rd_last      : current lane is the last valid lane of its wide word
//   rd_level     : narrow lanes available (output stage + prefetch + RAM)
module tx_fifo_gearbox #(
  parameter int    RD_DATA_WIDTH = 8,
  parameter int    RATIO         = 16,
  parameter int    DEPTH_WIDTH   = 8,
  parameter string LANE_ORDER    = "LSB_FIRST",
  parameter int    AFULL_THRESH  = (1 << DEPTH_WIDTH) - 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   wr_en,
  input  logic [RATIO*RD_DATA_WIDTH-1:0]         wr_data,
  input  logic [$clog2(RATIO):0]                 wr_lanes,
  output logic                                   wr_vld,
  output logic                                   almost_full,
  input  logic                                   rd_en,
  output logic                                   rd_vld,
  output logic [RD_DATA_WIDTH-1:0]               rd_data,
  output logic                                   rd_last,
  output logic [DEPTH_WIDTH+$clog2(RATIO):0]     rd_level
);

  localparam int WR_W    = RATIO * RD_DATA_WIDTH;
  localparam int IDX_W   = $clog2(RATIO);
  localparam int LANE_W  = IDX_W + 1;
  localparam int LVL_W   = DEPTH_WIDTH + IDX_W + 1;
  localparam int ENTRY_W = LANE_W + WR_W;
  localparam int ENTRIES = 1 << DEPTH_WIDTH;
  localparam bit L_MSB   = (LANE_ORDER == "MSB_FIRST");
  localparam logic [DEPTH_WIDTH:0] FULL_V  = (DEPTH_WIDTH+1)'(ENTRIES);
  localparam logic [DEPTH_WIDTH:0] AFULL_V = (DEPTH_WIDTH+1)'(AFULL_THRESH);

  // storage and prefetch register (registered RAM read port)
  logic [ENTRY_W-1:0]     r_mem [ENTRIES];
  logic [ENTRY_W-1:0]     r_pf_q;
  logic                   r_pf_vld;
  logic [DEPTH_WIDTH:0]   r_wr_ptr;
  logic [DEPTH_WIDTH:0]   r_rd_ptr;
  // wide words held anywhere: RAM + prefetch + output stage
  logic [DEPTH_WIDTH:0]   r_cnt;
  logic                   r_wr_vld;
  logic                   r_afull;
  logic [LVL_W-1:0]       r_level;

  // output stage
  logic [WR_W-1:0]        r_out_data;
  logic [LANE_W-1:0]      r_out_lanes;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_out_vld;

  logic [LANE_W-1:0]      w_lanes_norm;
  logic                   w_wr_acc;
  logic                   w_pop;
  logic                   w_last;
  logic                   w_pop_last;
  logic                   w_out_free;
  logic                   w_pf_take;
  logic                   w_rd_issue;
  logic [DEPTH_WIDTH:0]   w_cnt_next;
  logic [LVL_W-1:0]       w_level_next;
  logic [IDX_W-1:0]       w_lane_sel;
  logic [RD_DATA_WIDTH-1:0] w_lane [RATIO];

  assign w_lanes_norm = (wr_lanes == '0) ? LANE_W'(RATIO) : wr_lanes;
  assign w_wr_acc     = wr_en & r_wr_vld & ~flush;
  assign w_last       = r_out_vld & ({1'b0, r_idx} == (r_out_lanes - LANE_W'(1)));
  assign w_pop        = rd_en & r_out_vld & ~flush;
  assign w_pop_last   = w_pop & w_last;
  // output stage can take a new word this edge: empty, or retiring its last lane
  assign w_out_free   = ~r_out_vld | w_pop_last;
  assign w_pf_take    = r_pf_vld & w_out_free;
  // refill the prefetch register whenever it is empty or being drained
  assign w_rd_issue   = ~flush & (r_rd_ptr != r_wr_ptr) & (~r_pf_vld | w_pf_take);

  always_comb begin
    w_cnt_next   = r_cnt;
    w_level_next = r_level;
    if (w_wr_acc) begin
      w_cnt_next   = w_cnt_next + (DEPTH_WIDTH+1)'(1);
      w_level_next = w_level_next + LVL_W'(w_lanes_norm);
    end
    if (w_pop_last) w_cnt_next = w_cnt_next - (DEPTH_WIDTH+1)'(1);
    if (w_pop)      w_level_next = w_level_next - LVL_W'(1);
  end

  // RAM: write port plus registered read into the prefetch register
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[DEPTH_WIDTH-1:0]] <= {w_lanes_norm, wr_data};
    if (w_rd_issue) r_pf_q <= r_mem[r_rd_ptr[DEPTH_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_wr_vld    <= 1'b0;
      r_afull     <= 1'b0;
      r_level     <= '0;
      r_pf_vld    <= 1'b0;
      r_out_data  <= '0;
      r_out_lanes <= '0;
      r_idx       <= '0;
      r_out_vld   <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_wr_vld    <= 1'b1;
      r_afull     <= 1'b0;
      r_level     <= '0;
      r_pf_vld    <= 1'b0;
      r_out_data  <= '0;
      r_out_lanes <= '0;
      r_idx       <= '0;
      r_out_vld   <= 1'b0;
    end else begin
      if (w_wr_acc)   r_wr_ptr <= r_wr_ptr + (DEPTH_WIDTH+1)'(1);
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + (DEPTH_WIDTH+1)'(1);
      r_cnt    <= w_cnt_next;
      r_wr_vld <= (w_cnt_next < FULL_V);
      // deliberately one cycle behind the count
      r_afull  <= (r_cnt >= AFULL_V);
      r_level  <= w_level_next;

      if (w_rd_issue)     r_pf_vld <= 1'b1;
      else if (w_pf_take) r_pf_vld <= 1'b0;

      if (w_out_free) begin
        r_idx     <= '0;
        r_out_vld <= r_pf_vld;
        if (r_pf_vld) begin
          r_out_lanes <= r_pf_q[ENTRY_W-1 -: LANE_W];
          r_out_data  <= r_pf_q[WR_W-1:0];
        end
      end else if (w_pop) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign w_lane[gi] = r_out_data[gi*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end
  endgenerate

  assign w_lane_sel  = L_MSB ? (IDX_W'(RATIO - 1) - r_idx) : r_idx;
  assign rd_data     = w_lane[w_lane_sel];
  assign rd_vld      = r_out_vld;
  assign rd_last     = w_last;
  assign rd_level    = r_level;
  assign wr_vld      = r_wr_vld;
  assign almost_full = r_afull;

endmodule

// File: tb/tb_tx_fifo_gearbox.sv
module tb_tx_fifo_gearbox;

  localparam int RDW = 8;
  localparam int RAT = 16;
  localparam int DW  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         wr_en = 1'b0;
  logic [127:0] wr_data = '0;
  logic [4:0]   wr_lanes = '0;
  logic         wr_vld;
  logic         almost_full;
  logic         rd_en = 1'b0;
  logic         rd_vld;
  logic [7:0]   rd_data;
  logic         rd_last;
  logic [12:0]  rd_level;

  logic         m_flush = 1'b0;
  logic         m_wr_en = 1'b0;
  logic [127:0] m_wr_data = '0;
  logic [4:0]   m_wr_lanes = '0;
  logic         m_wr_vld;
  logic         m_almost_full;
  logic         m_rd_en = 1'b0;
  logic         m_rd_vld;
  logic [7:0]   m_rd_data;
  logic         m_rd_last;
  logic [12:0]  m_rd_level;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  tx_fifo_gearbox #(.RD_DATA_WIDTH(RDW), .RATIO(RAT), .DEPTH_WIDTH(DW),
                    .LANE_ORDER("LSB_FIRST"), .AFULL_THRESH(252)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_lanes(wr_lanes), .wr_vld(wr_vld), .almost_full(almost_full),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data), .rd_last(rd_last),
    .rd_level(rd_level));

  tx_fifo_gearbox #(.RD_DATA_WIDTH(RDW), .RATIO(RAT), .DEPTH_WIDTH(DW),
                    .LANE_ORDER("MSB_FIRST"), .AFULL_THRESH(252)) u_dut_msb (
    .clk(clk), .rst(rst), .flush(m_flush), .wr_en(m_wr_en), .wr_data(m_wr_data),
    .wr_lanes(m_wr_lanes), .wr_vld(m_wr_vld), .almost_full(m_almost_full),
    .rd_en(m_rd_en), .rd_vld(m_rd_vld), .rd_data(m_rd_data), .rd_last(m_rd_last),
    .rd_level(m_rd_level));

  // Scoreboard for the LSB_FIRST instance. Inputs change just after posedge,
  // so at negedge they describe exactly what the next posedge will do.
  always @(negedge clk) begin
    int   n;
    exp_t e;
    if (!rst) begin
      sb_q.delete();
    end else begin
      n_checks++;
      if (rd_level !== 13'(sb_q.size())) begin
        n_fail++;
        $display("FAIL sb_level: rd_level=%0d expected %0d", rd_level, sb_q.size());
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (rd_en && rd_vld) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_pop: rd_data=%h popped with nothing expected", rd_data);
          end else begin
            e = sb_q.pop_front();
            if (rd_data !== e.d || rd_last !== e.l) begin
              n_fail++;
              $display("FAIL sb_data: rd_data=%h rd_last=%0b expected %h/%0b",
                       rd_data, rd_last, e.d, e.l);
            end
          end
        end
        if (wr_en && wr_vld) begin
          n = (wr_lanes == 0) ? RAT : int'(wr_lanes);
          for (int i = 0; i < n; i++) begin
            e.d = wr_data[i*8 +: 8];
            e.l = (i == n - 1);
            sb_q.push_back(e);
          end
          n_wr++;
          $display("wr #%0d lanes=%0d data=%h", n_wr, n, wr_data);
        end
      end
    end
  end

  task automatic test_reset();
    #3;
    n_checks++;
    if (wr_vld !== 1'b0 || rd_vld !== 1'b0 || rd_last !== 1'b0 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: wr_vld=%0b rd_vld=%0b rd_last=%0b afull=%0b expected 0/0/0/0",
               wr_vld, rd_vld, rd_last, almost_full);
    end
    n_checks++;
    if (rd_data !== 8'h00 || rd_level !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_data: rd_data=%h rd_level=%0d expected 00/0", rd_data, rd_level);
    end
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (wr_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_wr_vld: got %0b expected 1", wr_vld);
    end
  endtask

  task automatic test_lsb_latency();
    logic [127:0] w;
    int cnt;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'(i);
    wr_data = w; wr_lanes = 5'd16; wr_en = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1; wr_en = 1'b0;
    n_checks++;
    if (rd_vld !== 1'b0 || rd_level !== 13'd16) begin
      n_fail++;
      $display("FAIL lat_t0: rd_vld=%0b rd_level=%0d expected 0/16", rd_vld, rd_level);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_t1: rd_vld=%0b expected 0", rd_vld);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rd_vld !== 1'b1 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL lat_t2: rd_vld=%0b rd_data=%h expected 1/00", rd_vld, rd_data);
    end
    cnt = 0;
    while (rd_vld && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    n_checks++;
    if (cnt != 16 || rd_level !== 13'd0) begin
      n_fail++;
      $display("FAIL lat_stream: lanes=%0d rd_level=%0d expected 16/0", cnt, rd_level);
    end
  endtask

  task automatic test_msb_partial();
    logic [127:0] w;
    logic [7:0] exp_d;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'(i);
    m_wr_data = w; m_wr_lanes = 5'd3; m_wr_en = 1'b1; m_rd_en = 1'b1;
    @(posedge clk); #1; m_wr_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (m_rd_level !== 13'd3) begin
      n_fail++;
      $display("FAIL msb_level: got %0d expected 3", m_rd_level);
    end
    for (int j = 0; j < 3; j++) begin
      exp_d = w[(15-j)*8 +: 8];
      n_checks++;
      if (m_rd_vld !== 1'b1 || m_rd_data !== exp_d || m_rd_last !== (j == 2)) begin
        n_fail++;
        $display("FAIL msb_lane%0d: vld=%0b data=%h last=%0b expected 1/%h/%0b",
                 j, m_rd_vld, m_rd_data, m_rd_last, exp_d, (j == 2));
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (m_rd_vld !== 1'b0 || m_rd_level !== 13'd0) begin
      n_fail++;
      $display("FAIL msb_end: vld=%0b level=%0d expected 0/0", m_rd_vld, m_rd_level);
    end
    m_rd_en = 1'b0;
  endtask

  task automatic test_fill_drain();
    int cnt;
    rd_en = 1'b0;
    for (int k = 0; k < 256; k++) begin
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      wr_lanes = (k % 2 == 0) ? 5'd16 : 5'd0;
      wr_en = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (wr_vld !== (k < 255) || almost_full !== (k >= 252)) begin
        n_fail++;
        $display("FAIL fill_k%0d: wr_vld=%0b afull=%0b expected %0b/%0b",
                 k, wr_vld, almost_full, (k < 255), (k >= 252));
      end
    end
    wr_data = {16{8'hEE}}; wr_lanes = 5'd16;
    @(posedge clk); #1; wr_en = 1'b0;
    n_checks++;
    if (wr_vld !== 1'b0 || rd_level !== 13'd4096 || almost_full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ignore: wr_vld=%0b level=%0d afull=%0b expected 0/4096/1",
               wr_vld, rd_level, almost_full);
    end
    rd_en = 1'b1;
    cnt = 0;
    while (rd_vld && cnt < 5000) begin
      cnt++;
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    n_checks++;
    if (cnt != 4096) begin
      n_fail++;
      $display("FAIL drain_gapless: lanes=%0d expected 4096", cnt);
    end
    @(posedge clk); #1;
    n_checks++;
    if (wr_vld !== 1'b1 || almost_full !== 1'b0 || rd_level !== 13'd0) begin
      n_fail++;
      $display("FAIL drain_end: wr_vld=%0b afull=%0b level=%0d expected 1/0/0",
               wr_vld, almost_full, rd_level);
    end
  endtask

  task automatic test_full_both();
    int acc;
    int guard;
    rd_en = 1'b0; wr_lanes = 5'd16; wr_en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      if (!wr_vld) break;
    end
    n_checks++;
    if (wr_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL full_fill: wr_vld=%0b expected 0", wr_vld);
    end
    rd_en = 1'b1;
    acc = 0;
    for (int c = 1; c <= 80; c++) begin
      if (wr_vld) acc++;
      @(posedge clk); #1;
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      if (c == 16) begin
        n_checks++;
        if (acc != 0) begin
          n_fail++;
          $display("FAIL full_no_bypass: accepts=%0d expected 0", acc);
        end
      end
    end
    wr_en = 1'b0;
    n_checks++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL full_one_per_retire: accepts=%0d expected 4", acc);
    end
    guard = 0;
    while ((rd_vld || rd_level != 0) && guard < 5000) begin
      guard++;
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    n_checks++;
    if (rd_vld !== 1'b0 || rd_level !== 13'd0) begin
      n_fail++;
      $display("FAIL full_drain: rd_vld=%0b level=%0d expected 0/0", rd_vld, rd_level);
    end
  endtask

  task automatic test_flush();
    logic [127:0] w;
    int guard;
    rd_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      wr_lanes = 5'($urandom_range(0, 16));
      wr_en = 1'b1;
      @(posedge clk); #1;
    end
    wr_data = {16{8'hAA}}; wr_lanes = 5'd16; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; wr_en = 1'b0;
    n_checks++;
    if (rd_vld !== 1'b0 || rd_level !== 13'd0 || wr_vld !== 1'b1 ||
        rd_data !== 8'h00 || rd_last !== 1'b0 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: vld=%0b level=%0d wr_vld=%0b data=%h last=%0b afull=%0b expected 0/0/1/00/0/0",
               rd_vld, rd_level, wr_vld, rd_data, rd_last, almost_full);
    end
    w = {$urandom, $urandom, $urandom, $urandom};
    w[7:0] = 8'h5C;
    wr_data = w; wr_lanes = 5'd2; wr_en = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1; wr_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (rd_vld !== 1'b1 || rd_data !== 8'h5C) begin
      n_fail++;
      $display("FAIL flush_next_word: vld=%0b data=%h expected 1/5c", rd_vld, rd_data);
    end
    guard = 0;
    while (rd_vld && guard < 50) begin
      guard++;
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    n_checks++;
    if (guard != 2 || rd_level !== 13'd0) begin
      n_fail++;
      $display("FAIL flush_drain: lanes=%0d level=%0d expected 2/0", guard, rd_level);
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] w;
    int guard;
    rd_en = 1'b0; wr_lanes = 5'd16; wr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    wr_en = 1'b0; rd_en = 1'b1;
    repeat (5) @(posedge clk);
    #3; rst = 1'b0;
    #1;
    n_checks++;
    if (rd_vld !== 1'b0 || rd_level !== 13'd0 || wr_vld !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: vld=%0b level=%0d wr_vld=%0b data=%h expected 0/0/0/00",
               rd_vld, rd_level, wr_vld, rd_data);
    end
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (wr_vld !== 1'b1 || rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL async_release: wr_vld=%0b rd_vld=%0b expected 1/0", wr_vld, rd_vld);
    end
    w = {$urandom, $urandom, $urandom, $urandom};
    wr_data = w; wr_lanes = 5'd5; wr_en = 1'b1;
    @(posedge clk); #1; wr_en = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (rd_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL async_lat_t1: rd_vld=%0b expected 0", rd_vld);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rd_vld !== 1'b1 || rd_data !== w[7:0]) begin
      n_fail++;
      $display("FAIL async_lat_t2: vld=%0b data=%h expected 1/%h", rd_vld, rd_data, w[7:0]);
    end
    guard = 0;
    while (rd_vld && guard < 50) begin
      guard++;
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    n_checks++;
    if (guard != 5 || rd_level !== 13'd0) begin
      n_fail++;
      $display("FAIL async_drain: lanes=%0d level=%0d expected 5/0", guard, rd_level);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_latency();
    test_msb_partial();
    test_fill_drain();
    test_full_both();
    test_flush();
    test_async_reset();
    @(posedge clk); #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d lanes never read, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
